mem_arbiter: RTL and testbench

Two-port arbiter and sequencer placed in front of the single-port word memory of the multi-cycle core. It shares one memory between an instruction-fetch requester (read-only) and a data requester (read/write) using a req/ack handshake. It also models a configurable number of memory wait states, so that the control FSM can be exercised against slow memory.

---
 rtl/mem_arb_pkg.sv | 27 ++
 rtl/mem_arbiter.sv | 141 ++++++++++++++
 tb/tb_mem_arbiter.sv | 328 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_arb_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Package : mem_arb_pkg                                                      |
// | Purpose : Shared types and constants for the two-port memory arbiter.      |
// |           state_t : arbiter FSM states                                     |
// |           grant_t : which requester owns the current transaction           |
// |           CNT_W   : width of the wait-state down-counter                   |
// | Rev     : 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
package mem_arb_pkg;

  // Width of the wait-state counter; covers WaitStates 0..15.
  localparam int CNT_W = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  typedef enum logic {
    GNT_I = 1'b0,
    GNT_D = 1'b1
  } grant_t;

endpackage : mem_arb_pkg
`default_nettype wire

// File: rtl/mem_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : mem_arbiter                                                      |
// | Purpose : Shares one single-port word memory between an instruction-fetch |
// |           requester (read-only) and a data requester (read/write) with a   |
// |           req/ack handshake and a configurable number of wait states.      |
// | Ports   : clk, reset (async, active-high)                                  |
// |           i_req/i_addr -> i_ack/i_rdata          fetch port                |
// |           d_req/d_we/d_addr/d_wdata -> d_ack/d_rdata   data port           |
// |           mem_we/mem_addr/mem_wdata, mem_rdata   memory side               |
// |           busy                                   high when not IDLE        |
// | Rev     : 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int WaitStates = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_req,
  input  logic [31:0] i_addr,
  output logic        i_ack,
  output logic [31:0] i_rdata,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic        d_ack,
  output logic [31:0] d_rdata,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  output logic        busy
);

  localparam logic [CNT_W-1:0] WAIT_INIT = CNT_W'(WaitStates);

  state_t             state_q,      state_d;
  logic [CNT_W-1:0]   wait_cnt_q,   wait_cnt_d;
  grant_t             gnt_q,        gnt_d;
  grant_t             last_grant_q, last_grant_d;
  logic [31:0]        addr_q,       addr_d;
  logic [31:0]        wdata_q,      wdata_d;
  logic               we_q,         we_d;
  logic [31:0]        rdata_q,      rdata_d;
  grant_t             pick;

  // The final ACCESS cycle is the one where the counter has run out.
  logic last_access;
  assign last_access = (state_q == ACCESS) && (wait_cnt_q == '0);

  always_comb begin
    state_d      = state_q;
    wait_cnt_d   = wait_cnt_q;
    gnt_d        = gnt_q;
    last_grant_d = last_grant_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    we_d         = we_q;
    rdata_d      = rdata_q;

    // A lone request wins outright; on a tie the port not served last wins.
    if (i_req && d_req) begin
      pick = (last_grant_q == GNT_D) ? GNT_I : GNT_D;
    end else begin
      pick = d_req ? GNT_D : GNT_I;
    end

    case (state_q)
      IDLE: begin
        if (i_req || d_req) begin
          gnt_d = pick;
          if (pick == GNT_D) begin
            addr_d  = d_addr;
            wdata_d = d_wdata;
            we_d    = d_we;
          end else begin
            // Fetch has no write data; keep the bus value, never write.
            addr_d  = i_addr;
            we_d    = 1'b0;
          end
          wait_cnt_d = WAIT_INIT;
          state_d    = ACCESS;
        end
      end
      ACCESS: begin
        if (wait_cnt_q == '0) begin
          // Captured in the same cycle as the write, so a write returns
          // the word that was in memory before it.
          rdata_d = mem_rdata;
          state_d = RESP;
        end else begin
          wait_cnt_d = wait_cnt_q - 1'b1;
        end
      end
      RESP: begin
        last_grant_d = gnt_q;
        state_d      = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      wait_cnt_q   <= '0;
      gnt_q        <= GNT_I;
      last_grant_q <= GNT_D;
      addr_q       <= '0;
      wdata_q      <= '0;
      we_q         <= 1'b0;
      rdata_q      <= '0;
    end else begin
      state_q      <= state_d;
      wait_cnt_q   <= wait_cnt_d;
      gnt_q        <= gnt_d;
      last_grant_q <= last_grant_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      we_q         <= we_d;
      rdata_q      <= rdata_d;
    end
  end

  // Outputs decode straight from state so reset removes them immediately.
  assign mem_we    = last_access && we_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign i_ack     = (state_q == RESP) && (gnt_q == GNT_I);
  assign d_ack     = (state_q == RESP) && (gnt_q == GNT_D);
  assign i_rdata   = rdata_q;
  assign d_rdata   = rdata_q;
  assign busy      = (state_q != IDLE);

endmodule : mem_arbiter
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : tb_mem_arbiter                                                   |
// | Purpose : Self-checking bench for mem_arbiter: directed scenarios plus     |
// |           randomized two-port traffic against a transaction-level model.   |
// | Rev     : 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
module tb_mem_arbiter;

  localparam int WS = 2;

  logic        clk;
  logic        reset;
  logic        i_req,  d_req, d_we;
  logic [31:0] i_addr, d_addr, d_wdata;
  logic        i_ack,  d_ack, mem_we, busy;
  logic [31:0] i_rdata, d_rdata, mem_addr, mem_wdata, mem_rdata;

  logic        z_i_req,  z_d_req, z_d_we;
  logic [31:0] z_i_addr, z_d_addr, z_d_wdata;
  logic        z_i_ack,  z_d_ack, z_mem_we, z_busy;
  logic [31:0] z_i_rdata, z_d_rdata, z_mem_addr, z_mem_wdata, z_mem_rdata;

  mem_arbiter #(.WaitStates(WS)) dut (
    .clk(clk), .reset(reset),
    .i_req(i_req), .i_addr(i_addr), .i_ack(i_ack), .i_rdata(i_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_ack(d_ack), .d_rdata(d_rdata),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .busy(busy)
  );

  mem_arbiter #(.WaitStates(0)) dut0 (
    .clk(clk), .reset(reset),
    .i_req(z_i_req), .i_addr(z_i_addr), .i_ack(z_i_ack), .i_rdata(z_i_rdata),
    .d_req(z_d_req), .d_we(z_d_we), .d_addr(z_d_addr), .d_wdata(z_d_wdata),
    .d_ack(z_d_ack), .d_rdata(z_d_rdata),
    .mem_we(z_mem_we), .mem_addr(z_mem_addr), .mem_wdata(z_mem_wdata),
    .mem_rdata(z_mem_rdata), .busy(z_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- memory behind the main instance ----------------
  logic [31:0] mem [256];
  bit          written [256];
  int          we_pulses = 0;
  int          dack_pulses = 0;

  function automatic logic [31:0] init_word(input logic [7:0] idx);
    if (idx == 8'd1)  return 32'h20100005;
    if (idx == 8'd16) return 32'h0;
    return {idx, ~idx, idx ^ 8'h3C, 8'hA5};
  endfunction

  assign mem_rdata = written[mem_addr[9:2]] ? mem[mem_addr[9:2]]
                                            : init_word(mem_addr[9:2]);

  always @(posedge clk) begin
    if (mem_we) begin
      mem[mem_addr[9:2]]     <= mem_wdata;
      written[mem_addr[9:2]] <= 1'b1;
      we_pulses              <= we_pulses + 1;
    end
    if (d_ack) dack_pulses <= dack_pulses + 1;
  end

  // Read-only pattern memory for the zero-wait instance.
  assign z_mem_rdata = z_mem_addr ^ 32'hA5A5A5A5;

  // ---------------- reference model state ----------------
  logic [31:0] ref_mem [256];
  int          cyc;
  bit          exp_valid;
  bit          exp_port_d;
  bit          exp_we;
  int          exp_ack_cyc;
  logic [31:0] exp_data, exp_addr, exp_wdata;
  bit          model_last_d;
  int          next_idle;
  bit          seen_i, seen_d;
  int          checks = 0;
  int          errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock cycle: compare outputs against the model, let the model decide
  // on a new grant, then advance to just after the next rising edge.
  task automatic step();
    bit ack_now, we_now;
    @(negedge clk);
    ack_now = exp_valid && (cyc == exp_ack_cyc);
    we_now  = exp_valid && exp_we && (cyc == exp_ack_cyc - 1);
    chk("busy",   {31'b0, busy},   {31'b0, exp_valid});
    chk("i_ack",  {31'b0, i_ack},  {31'b0, ack_now && !exp_port_d});
    chk("d_ack",  {31'b0, d_ack},  {31'b0, ack_now && exp_port_d});
    chk("mem_we", {31'b0, mem_we}, {31'b0, we_now});
    if (exp_valid && cyc < exp_ack_cyc) begin
      chk("mem_addr", mem_addr, exp_addr);
      if (exp_we) chk("mem_wdata", mem_wdata, exp_wdata);
    end
    if (ack_now) begin
      if (exp_port_d) chk("d_rdata", d_rdata, exp_data);
      else            chk("i_rdata", i_rdata, exp_data);
      exp_valid    = 1'b0;
      model_last_d = exp_port_d;
      next_idle    = cyc + 1;
    end
    seen_i = i_ack;
    seen_d = d_ack;
    if (!exp_valid && cyc >= next_idle && (i_req || d_req)) begin
      exp_port_d  = (i_req && d_req) ? !model_last_d : d_req;
      exp_valid   = 1'b1;
      exp_ack_cyc = cyc + WS + 2;
      exp_addr    = exp_port_d ? d_addr : i_addr;
      exp_we      = exp_port_d && d_we;
      exp_wdata   = d_wdata;
      exp_data    = ref_mem[exp_addr[9:2]];
      if (exp_we) ref_mem[exp_addr[9:2]] = d_wdata;
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic drain();
    for (int k = 0; k < 40 && exp_valid; k++) step();
    chk("drain_timeout", {31'b0, exp_valid}, 32'd0);
  endtask

  task automatic model_resync();
    exp_valid    = 1'b0;
    model_last_d = 1'b1;
    next_idle    = cyc;
  endtask

  task automatic txn(input bit port_d, input bit we, input logic [31:0] addr,
                     input logic [31:0] wdata, output logic [31:0] rd, output int lat);
    int start;
    bit got;
    start = cyc;
    got   = 1'b0;
    lat   = -1;
    rd    = '0;
    if (port_d) begin
      d_req = 1'b1; d_we = we; d_addr = addr; d_wdata = wdata;
    end else begin
      i_req = 1'b1; i_addr = addr;
    end
    for (int k = 0; k < 40 && !got; k++) begin
      step();
      if (port_d ? seen_d : seen_i) begin
        got = 1'b1;
        lat = cyc - 1 - start;
        rd  = port_d ? d_rdata : i_rdata;
      end
    end
    i_req = 1'b0;
    d_req = 1'b0;
    d_we  = 1'b0;
    chk("txn_timeout", {31'b0, got}, 32'd1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rd;
    int          lat, start, n, wp0, da0;
    int          a_cyc [3];
    bit          a_d   [3];
    int          z_ack [2];
    int          zn;

    reset = 1'b1;
    i_req = 0; i_addr = '0; d_req = 0; d_we = 0; d_addr = '0; d_wdata = '0;
    z_i_req = 0; z_i_addr = '0; z_d_req = 0; z_d_we = 0; z_d_addr = '0; z_d_wdata = '0;
    for (int k = 0; k < 256; k++) ref_mem[k] = init_word(k[7:0]);
    cyc = 0;

    // ---- reset held for three cycles ----
    repeat (3) @(posedge clk);
    #1;
    chk("rst_i_ack",     {31'b0, i_ack},  32'd0);
    chk("rst_d_ack",     {31'b0, d_ack},  32'd0);
    chk("rst_mem_we",    {31'b0, mem_we}, 32'd0);
    chk("rst_busy",      {31'b0, busy},   32'd0);
    chk("rst_mem_addr",  mem_addr,  32'd0);
    chk("rst_mem_wdata", mem_wdata, 32'd0);
    chk("rst_i_rdata",   i_rdata,   32'd0);
    chk("rst_d_rdata",   d_rdata,   32'd0);
    chk("rst_z_wdata",   z_mem_wdata, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
    model_resync();
    for (int k = 0; k < 3; k++) step();
    chk("rst_no_write", we_pulses, 32'd0);

    // ---- fetch of word 1 ----
    txn(1'b0, 1'b0, 32'h00000004, 32'h0, rd, lat);
    chk("fetch_lat",   lat, 32'd4);
    chk("fetch_rdata", rd,  32'h20100005);
    chk("fetch_no_we", we_pulses, 32'd0);

    // ---- reset pulsed in cycle 2 of a write to 0x40 ----
    wp0 = we_pulses; da0 = dack_pulses;
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h40; d_wdata = 32'h12345678;
    @(posedge clk); #1;
    @(negedge clk);
    chk("rmw_c1_mem_we", {31'b0, mem_we}, 32'd0);
    @(posedge clk); #1;
    reset = 1'b1;
    #1;
    chk("rmw_busy",   {31'b0, busy},   32'd0);
    chk("rmw_mem_we", {31'b0, mem_we}, 32'd0);
    chk("rmw_d_ack",  {31'b0, d_ack},  32'd0);
    @(negedge clk);
    reset = 1'b0; d_req = 1'b0; d_we = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      cyc++;
    end
    chk("rmw_we_pulses",   we_pulses - wp0,   32'd0);
    chk("rmw_dack_pulses", dack_pulses - da0, 32'd0);
    model_resync();
    txn(1'b1, 1'b0, 32'h40, 32'h0, rd, lat);
    chk("rmw_readback", rd, 32'h0);

    // ---- data write then read-back ----
    wp0 = we_pulses;
    txn(1'b1, 1'b1, 32'h40, 32'hDEADBEEF, rd, lat);
    chk("wr_lat",       lat, 32'd4);
    chk("wr_one_pulse", we_pulses - wp0, 32'd1);
    txn(1'b1, 1'b0, 32'h40, 32'h0, rd, lat);
    chk("wr_readback", rd, 32'hDEADBEEF);

    // ---- contention: both ports re-raise after each ack ----
    start = cyc; n = 0;
    i_req = 1'b1; i_addr = 32'h8; d_req = 1'b1; d_we = 1'b0; d_addr = 32'h40;
    for (int k = 0; k < 16; k++) begin
      step();
      if ((seen_i || seen_d) && n < 3) begin
        a_cyc[n] = cyc - 1 - start;
        a_d[n]   = seen_d;
        n++;
      end
      i_req = !seen_i;
      d_req = !seen_d;
    end
    i_req = 1'b0; d_req = 1'b0;
    drain();
    chk("cont_count", n, 32'd3);
    chk("cont_ack0_cyc", a_cyc[0], 32'd4);
    chk("cont_ack0_d",   {31'b0, a_d[0]}, 32'd0);
    chk("cont_ack1_cyc", a_cyc[1], 32'd9);
    chk("cont_ack1_d",   {31'b0, a_d[1]}, 32'd1);
    chk("cont_ack2_cyc", a_cyc[2], 32'd14);
    chk("cont_ack2_d",   {31'b0, a_d[2]}, 32'd0);

    // ---- randomized traffic on both ports ----
    for (int k = 0; k < 1500; k++) begin
      step();
      if (seen_i) i_req = 1'b0;
      else if (!i_req && $urandom_range(0, 2) == 0) begin
        i_req  = 1'b1;
        i_addr = $urandom_range(0, 1023);
      end
      if (seen_d) begin
        d_req = 1'b0; d_we = 1'b0;
      end else if (!d_req && $urandom_range(0, 2) == 0) begin
        d_req   = 1'b1;
        d_we    = ($urandom_range(0, 1) == 1);
        d_addr  = $urandom_range(0, 1023);
        d_wdata = $urandom;
      end
    end
    i_req = 1'b0; d_req = 1'b0; d_we = 1'b0;
    drain();

    // ---- zero-wait instance: fetch ----
    z_i_req = 1'b1; z_i_addr = 32'h10; zn = -1;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (z_i_ack && zn < 0) begin
        zn = k;
        chk("z_fetch_rdata", z_i_rdata, 32'h10 ^ 32'hA5A5A5A5);
      end
      @(posedge clk); #1;
      if (zn >= 0) z_i_req = 1'b0;
    end
    chk("z_fetch_ack_cyc", zn, 32'd2);

    // ---- zero-wait instance: two back-to-back data reads ----
    z_d_req = 1'b1; z_d_we = 1'b0; z_d_addr = 32'h20; zn = 0;
    z_ack[0] = -1; z_ack[1] = -1;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      chk("z_mem_we", {31'b0, z_mem_we}, 32'd0);
      if (z_d_ack && zn < 2) begin
        z_ack[zn] = k;
        chk("z_read_rdata", z_d_rdata, z_d_addr ^ 32'hA5A5A5A5);
        zn++;
      end
      @(posedge clk); #1;
      if (zn == 1) z_d_addr = 32'h24;
      if (zn == 2) z_d_req  = 1'b0;
    end
    chk("z_read0_ack_cyc", z_ack[0], 32'd2);
    chk("z_read1_ack_cyc", z_ack[1], 32'd5);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_mem_arbiter
`default_nettype wire
